// File: rtl/ad_decimator_if.sv
// ---------------------------------------------------------------------------
// ad_decimator_if
// Purpose : Groups the sample/config inputs and the decimated-sample outputs
//           of ad_decimator into one bundle in the ad_clk domain.
// Signals : ad_data    - raw ADC sample, one per ad_clk
//           deci_rate  - decimation ratio R (0 and 1 both mean R=1)
//           deci_mode  - 0=first, 1=max, 2=min, 3=alternate max/min
//           deci_clr   - synchronous window restart
//           deci_valid - one-cycle strobe marking a decimated sample
//           deci_data  - decimated sample, held between strobes
// Modports: master - sample source / controller side
//           slave  - decimator side
// ---------------------------------------------------------------------------
interface ad_decimator_if #(
    parameter int DW = 8,
    parameter int RW = 10
);
    logic [DW-1:0] ad_data;
    logic [RW-1:0] deci_rate;
    logic [1:0]    deci_mode;
    logic          deci_clr;
    logic          deci_valid;
    logic [DW-1:0] deci_data;

    modport master (
        output ad_data,
        output deci_rate,
        output deci_mode,
        output deci_clr,
        input  deci_valid,
        input  deci_data
    );

    modport slave (
        input  ad_data,
        input  deci_rate,
        input  deci_mode,
        input  deci_clr,
        output deci_valid,
        output deci_data
    );
endinterface

// File: rtl/ad_decimator.sv
// ---------------------------------------------------------------------------
// ad_decimator
// Purpose : Reduces the raw ADC stream by a programmable ratio R, emitting
//           one sample per window of R input samples. The window result is
//           the first sample, the max, the min, or alternately max/min so
//           that short glitches survive slow timebases.
// Ports   : ad_clk - sole clock
//           rst_n  - synchronous active-low reset
//           bus    - ad_decimator_if.slave (ad_data, deci_rate, deci_mode,
//                    deci_clr in; deci_valid, deci_data out)
// Timing  : the result is registered in the last cycle of a window and
//           presented with deci_valid=1 one ad_clk later.
// ---------------------------------------------------------------------------
module ad_decimator #(
    parameter int DW = 8,
    parameter int RW = 10
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    ad_decimator_if.slave     bus
);

    localparam logic [RW-1:0] CNT_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] RATE_ONE   = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO  = {DW{1'b0}};
    localparam logic [1:0]    MODE_FIRST = 2'd0;
    localparam logic [1:0]    MODE_MAX   = 2'd1;
    localparam logic [1:0]    MODE_MIN   = 2'd2;
    localparam logic [1:0]    MODE_ALT   = 2'd3;

    // Combine accumulator and new sample according to the window mode.
    // Compares are unsigned; mode 3 uses max while alt=0 and min while alt=1.
    function automatic logic [DW-1:0] f_accumulate(
        input logic [DW-1:0] acc,
        input logic [DW-1:0] smp,
        input logic [1:0]    mode,
        input logic          alt
    );
        logic [DW-1:0] res;
        case (mode)
            MODE_FIRST: res = acc;
            MODE_MAX:   res = (smp > acc) ? smp : acc;
            MODE_MIN:   res = (smp < acc) ? smp : acc;
            MODE_ALT: begin
                if (alt) begin
                    res = (smp < acc) ? smp : acc;
                end else begin
                    res = (smp > acc) ? smp : acc;
                end
            end
            default:    res = acc;
        endcase
        return res;
    endfunction

    // Registered state
    logic [RW-1:0] cnt_q,   cnt_d;
    logic [RW-1:0] rate_q,  rate_d;
    logic [1:0]    mode_q,  mode_d;
    logic [DW-1:0] acc_q,   acc_d;
    logic          alt_q,   alt_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    // Combinational helpers
    logic          win_start_s;
    logic          win_end_s;
    logic [RW-1:0] rate_in_s;
    logic [RW-1:0] rate_eff_s;
    logic [1:0]    mode_eff_s;
    logic [DW-1:0] acc_next_s;

    // Effective configuration: in the first cycle of a window the live inputs
    // apply immediately (needed so that R=1 completes in that same cycle);
    // for the rest of the window the latched copy is used.
    always_comb begin
        rate_in_s   = (bus.deci_rate == CNT_ZERO) ? RATE_ONE : bus.deci_rate;
        win_start_s = (cnt_q == CNT_ZERO);
        if (win_start_s) begin
            rate_eff_s = rate_in_s;
            mode_eff_s = bus.deci_mode;
        end else begin
            rate_eff_s = rate_q;
            mode_eff_s = mode_q;
        end
        win_end_s = (cnt_q == (rate_eff_s - RATE_ONE));
    end

    // Window datapath: first sample seeds the accumulator, later samples fold in.
    always_comb begin
        if (win_start_s) begin
            acc_next_s = bus.ad_data;
        end else begin
            acc_next_s = f_accumulate(acc_q, bus.ad_data, mode_eff_s, alt_q);
        end
    end

    // Next-state logic for counter, accumulator, toggle, config and output.
    always_comb begin
        rate_d  = rate_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        alt_d   = alt_q;
        valid_d = 1'b0;
        data_d  = data_q;

        // Config is only ever captured on the first sample of a window.
        if (win_start_s) begin
            rate_d = rate_in_s;
            mode_d = bus.deci_mode;
        end else begin
            rate_d = rate_q;
            mode_d = mode_q;
        end

        if (bus.deci_clr) begin
            // Abort: drop the partial window, including one that would end now.
            cnt_d   = CNT_ZERO;
            acc_d   = DATA_ZERO;
            alt_d   = 1'b0;
            valid_d = 1'b0;
            data_d  = data_q;
        end else begin
            acc_d = acc_next_s;
            if (win_end_s) begin
                cnt_d   = CNT_ZERO;
                valid_d = 1'b1;
                data_d  = acc_next_s;
            end else begin
                cnt_d   = cnt_q + RATE_ONE;
                valid_d = 1'b0;
                data_d  = data_q;
            end
            // Leaving mode 3 parks alt at 0 so re-entry starts with a max window.
            if (mode_eff_s != MODE_ALT) begin
                alt_d = 1'b0;
            end else if (win_end_s) begin
                alt_d = ~alt_q;
            end else begin
                alt_d = alt_q;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            cnt_q   <= CNT_ZERO;
            rate_q  <= RATE_ONE;
            mode_q  <= MODE_FIRST;
            acc_q   <= DATA_ZERO;
            alt_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= DATA_ZERO;
        end else begin
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            alt_q   <= alt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.deci_valid = valid_q;
    assign bus.deci_data  = data_q;

endmodule
